// File: rtl/sm_merge.sv
// sm_merge: N-channel sample merger. Per-channel one-entry hold registers are drained
// round-robin into a single registered ready/valid output, with an optional frame mode.
module sm_merge #(
   parameter int CH = 8,
   parameter int DW = 16
) (
   input  logic               clk_sys,
   input  logic               rst,
   input  logic [5:0]         dev_id,
   input  logic [CH*DW-1:0]   ch_data,
   input  logic [CH-1:0]      ch_vld,
   output logic [DW-1:0]      out_data,
   output logic [3:0]         out_ch,
   output logic               out_sof,
   output logic               out_vld,
   input  logic               out_rdy,
   input  logic [21:0]        fx_waddr,
   input  logic               fx_wr,
   input  logic [7:0]         fx_data,
   input  logic [21:0]        fx_raddr,
   input  logic               fx_rd,
   output logic [7:0]         fx_q
);

   localparam logic [7:0] OFF_EN_LO   = 8'h00;
   localparam logic [7:0] OFF_EN_HI   = 8'h01;
   localparam logic [7:0] OFF_OVF_LO  = 8'h02;
   localparam logic [7:0] OFF_OVF_HI  = 8'h03;
   localparam logic [7:0] OFF_CTRL    = 8'h04;
   localparam logic [7:0] OFF_FCNT_LO = 8'h05;
   localparam logic [7:0] OFF_FCNT_HI = 8'h06;
   localparam logic [3:0] PTR_RST     = 4'(CH - 1);

   logic [CH-1:0]         hold_full_q, hold_full_d;
   logic [CH-1:0][DW-1:0] hold_data_q, hold_data_d;
   logic [CH-1:0]         en_q, en_d;
   logic [CH-1:0]         ovf_q, ovf_d;
   logic [CH-1:0]         seen_q, seen_d;
   logic                  mode_q, mode_d;
   logic                  sof_pend_q, sof_pend_d;
   logic [15:0]           fcnt_q, fcnt_d;
   logic [3:0]            ptr_q, ptr_d;
   logic                  out_vld_q, out_vld_d;
   logic [DW-1:0]         out_data_q, out_data_d;
   logic [3:0]            out_ch_q, out_ch_d;
   logic                  out_sof_q, out_sof_d;
   logic [7:0]            fx_q_q, fx_q_d;

   logic          wr_sel, rd_sel, ctrl_wr, load_ok, grant_vld, frame_done;
   logic [3:0]    grant_idx;
   logic [CH-1:0] eligible, grant_oh, seen_after;
   logic [DW-1:0] grant_data;
   logic [15:0]   wdata16, en16, ovf16;
   logic [7:0]    rdata;

   assign wr_sel  = fx_wr && (fx_waddr[21:16] == dev_id);
   assign rd_sel  = fx_rd && (fx_raddr[21:16] == dev_id);
   // Any CTRL write (MODE or FLUSH) restarts collection: holds and seen bits are dropped.
   assign ctrl_wr = wr_sel && (fx_waddr[7:0] == OFF_CTRL);
   assign load_ok = !out_vld_q || out_rdy;
   assign wdata16 = {fx_data, fx_data};
   assign en16    = 16'(en_q);
   assign ovf16   = 16'(ovf_q);

   always_comb begin
      int idx;
      idx        = 0;
      eligible   = hold_full_q & en_q & (mode_q ? ~seen_q : '1);
      grant_vld  = 1'b0;
      grant_idx  = '0;
      grant_data = '0;
      grant_oh   = '0;
      // NOTE: blocking assignments in always_comb; the search relies on grant_vld updating in-loop.
      for (int k = 1; k <= CH; k++) begin
         idx = (int'(ptr_q) + k) % CH;
         if (!grant_vld && eligible[idx] && load_ok && !ctrl_wr) begin
            grant_vld     = 1'b1;
            grant_idx     = 4'(idx);
            grant_data    = hold_data_q[idx];
            grant_oh[idx] = 1'b1;
         end
      end
      seen_after = seen_q | grant_oh;
      frame_done = grant_vld && mode_q && ((seen_after & en_q) == en_q);
   end

   always_comb begin
      hold_full_d = hold_full_q;
      hold_data_d = hold_data_q;
      ovf_d       = ovf_q;
      en_d        = en_q;
      for (int i = 0; i < CH; i++) begin
         if (wr_sel && fx_waddr[7:0] == ((i < 8) ? OFF_EN_LO : OFF_EN_HI))
            en_d[i] = wdata16[i];
         if (wr_sel && fx_waddr[7:0] == ((i < 8) ? OFF_OVF_LO : OFF_OVF_HI) && wdata16[i])
            ovf_d[i] = 1'b0;
         if (!en_q[i] || ctrl_wr) begin
            hold_full_d[i] = 1'b0;
         end else begin
            if (grant_oh[i])
               hold_full_d[i] = 1'b0;
            // A hold being granted this cycle may accept the new sample; set wins over clear.
            if (ch_vld[i]) begin
               if (!hold_full_q[i] || grant_oh[i]) begin
                  hold_full_d[i] = 1'b1;
                  hold_data_d[i] = ch_data[i*DW +: DW];
               end else begin
                  ovf_d[i] = 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      mode_d     = mode_q;
      seen_d     = seen_q;
      sof_pend_d = sof_pend_q;
      fcnt_d     = fcnt_q;
      ptr_d      = ptr_q;
      out_vld_d  = out_vld_q;
      out_data_d = out_data_q;
      out_ch_d   = out_ch_q;
      out_sof_d  = out_sof_q;
      if (grant_vld) begin
         ptr_d      = grant_idx;
         sof_pend_d = 1'b0;
         if (mode_q)
            seen_d = seen_after;
      end
      if (frame_done) begin
         seen_d     = '0;
         sof_pend_d = 1'b1;
         fcnt_d     = fcnt_q + 16'd1;
      end
      if (ctrl_wr) begin
         mode_d     = fx_data[0];
         seen_d     = '0;
         sof_pend_d = 1'b1;
      end
      if (load_ok) begin
         out_vld_d = grant_vld;
         if (grant_vld) begin
            out_data_d = grant_data;
            out_ch_d   = grant_idx;
            out_sof_d  = mode_q && sof_pend_q;
         end
      end

      case (fx_raddr[7:0])
         OFF_EN_LO:   rdata = en16[7:0];
         OFF_EN_HI:   rdata = en16[15:8];
         OFF_OVF_LO:  rdata = ovf16[7:0];
         OFF_OVF_HI:  rdata = ovf16[15:8];
         OFF_CTRL:    rdata = {7'b0, mode_q};
         OFF_FCNT_LO: rdata = fcnt_q[7:0];
         OFF_FCNT_HI: rdata = fcnt_q[15:8];
         default:     rdata = 8'h00;
      endcase
      fx_q_d = fx_q_q;
      if (fx_rd)
         fx_q_d = rd_sel ? rdata : 8'h00;
   end

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         hold_full_q <= '0;
         en_q        <= '1;
         ovf_q       <= '0;
         seen_q      <= '0;
         mode_q      <= 1'b0;
         sof_pend_q  <= 1'b1;
         fcnt_q      <= '0;
         ptr_q       <= PTR_RST;
         out_vld_q   <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         out_sof_q   <= 1'b0;
         fx_q_q      <= '0;
      end else begin
         hold_full_q <= hold_full_d;
         en_q        <= en_d;
         ovf_q       <= ovf_d;
         seen_q      <= seen_d;
         mode_q      <= mode_d;
         sof_pend_q  <= sof_pend_d;
         fcnt_q      <= fcnt_d;
         ptr_q       <= ptr_d;
         out_vld_q   <= out_vld_d;
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         out_sof_q   <= out_sof_d;
         fx_q_q      <= fx_q_d;
      end
   end

   // NOTE: hold data is not reset; it is only observed while the matching full flag is set.
   always_ff @(posedge clk_sys) begin
      hold_data_q <= hold_data_d;
   end

   assign out_vld  = out_vld_q;
   assign out_data = out_data_q;
   assign out_ch   = out_ch_q;
   assign out_sof  = out_sof_q;
   assign fx_q     = fx_q_q;

endmodule

// File: tb/tb_sm_merge.sv
// Directed testbench for sm_merge: expected outputs are queued by the stimulus
// process and popped by an independent monitor on every output handshake.
module tb_sm_merge;

   localparam int CH = 8;
   localparam int DW = 16;
   localparam logic [5:0] DEV = 6'h2A;

   logic               clk_sys = 1'b0;
   logic               rst;
   logic [5:0]         dev_id;
   logic [CH*DW-1:0]   ch_data;
   logic [CH-1:0]      ch_vld;
   logic [DW-1:0]      out_data;
   logic [3:0]         out_ch;
   logic               out_sof;
   logic               out_vld;
   logic               out_rdy;
   logic [21:0]        fx_waddr;
   logic               fx_wr;
   logic [7:0]         fx_data;
   logic [21:0]        fx_raddr;
   logic               fx_rd;
   logic [7:0]         fx_q;

   typedef struct packed {
      logic [15:0] data;
      logic [3:0]  ch;
      logic        sof;
   } exp_t;

   exp_t  exp_q[$];
   int    n_tests = 0;
   int    n_fail  = 0;
   bit    mon_off = 1'b0;
   string phase   = "init";

   sm_merge #(.CH(CH), .DW(DW)) dut (
      .clk_sys  (clk_sys),
      .rst      (rst),
      .dev_id   (dev_id),
      .ch_data  (ch_data),
      .ch_vld   (ch_vld),
      .out_data (out_data),
      .out_ch   (out_ch),
      .out_sof  (out_sof),
      .out_vld  (out_vld),
      .out_rdy  (out_rdy),
      .fx_waddr (fx_waddr),
      .fx_wr    (fx_wr),
      .fx_data  (fx_data),
      .fx_raddr (fx_raddr),
      .fx_rd    (fx_rd),
      .fx_q     (fx_q)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL [%s] %s: got 0x%0h, expected 0x%0h", phase, name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_q.delete();
   endtask

   task automatic fx_write(input logic [7:0] off, input logic [7:0] d);
      fx_waddr = {DEV, 8'h00, off};
      fx_data  = d;
      fx_wr    = 1'b1;
      tick();
      fx_wr    = 1'b0;
   endtask

   task automatic fx_read(input logic [5:0] dev, input logic [7:0] off, input string name,
                          input logic [7:0] exp);
      fx_raddr = {dev, 8'h00, off};
      fx_rd    = 1'b1;
      tick();
      fx_rd    = 1'b0;
      check(name, 32'(fx_q), 32'(exp));
   endtask

   task automatic pulse_one(input int ch, input logic [15:0] d);
      ch_data[ch*DW +: DW] = d;
      ch_vld = CH'(1 << ch);
      tick();
      ch_vld = '0;
   endtask

   task automatic expect_out(input logic [15:0] d, input logic [3:0] ch, input logic sof);
      exp_t e;
      e.data = d;
      e.ch   = ch;
      e.sof  = sof;
      exp_q.push_back(e);
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((exp_q.size() != 0 || out_vld) && n < 200) begin
         tick();
         n++;
      end
      check("drain_complete", 32'(exp_q.size() != 0 || out_vld), 32'd0);
      exp_q.delete();
   endtask

   // Monitor: a handshake seen at the falling edge completes on the next rising edge.
   always @(negedge clk_sys) begin
      if (!mon_off && !rst && out_vld && out_rdy) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL [%s] unexpected_output: got ch %0d data 0x%0h, expected none",
                     phase, out_ch, out_data);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("out_data", 32'(out_data), 32'(e.data));
            check("out_ch",   32'(out_ch),   32'(e.ch));
            check("out_sof",  32'(out_sof),  32'(e.sof));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; dev_id = DEV; ch_data = '0; ch_vld = '0; out_rdy = 1'b1;
      fx_waddr = '0; fx_wr = 1'b0; fx_data = '0; fx_raddr = '0; fx_rd = 1'b0;
      tick();
      do_reset();

      phase = "reset";
      check("out_vld",  32'(out_vld),  0);
      check("out_data", 32'(out_data), 0);
      check("out_ch",   32'(out_ch),   0);
      check("out_sof",  32'(out_sof),  0);
      check("fx_q",     32'(fx_q),     0);
      fx_read(DEV,   8'h00, "en_lo_match",    8'hFF);
      fx_read(6'h15, 8'h00, "en_lo_nomatch",  8'h00);
      fx_read(DEV,   8'h01, "en_hi",          8'h00);
      fx_read(DEV,   8'h04, "ctrl",           8'h00);
      fx_read(DEV,   8'h05, "fcnt_lo",        8'h00);
      fx_write(8'h01, 8'hFF);
      fx_read(DEV,   8'h01, "en_hi_above_ch", 8'h00);

      phase = "stream";
      for (int i = 0; i < CH; i++) begin
         ch_data[i*DW +: DW] = 16'h1000 + 16'(i);
         expect_out(16'h1000 + 16'(i), 4'(i), 1'b0);
      end
      ch_vld = '1;
      tick();
      ch_vld = '0;
      tick();
      check("first_latency_vld", 32'(out_vld), 1);
      check("first_latency_ch",  32'(out_ch),  0);
      repeat (7) tick();
      check("last_back_to_back_vld", 32'(out_vld), 1);
      check("last_back_to_back_ch",  32'(out_ch),  7);
      tick();
      check("idle_after_burst", 32'(out_vld), 0);
      wait_drain();

      phase = "backpressure";
      do_reset();
      out_rdy = 1'b0;
      expect_out(16'h0BAD, 4'd5, 1'b0);
      expect_out(16'hAAAA, 4'd2, 1'b0);
      pulse_one(5, 16'h0BAD);
      pulse_one(2, 16'hAAAA);
      pulse_one(2, 16'h5555);
      tick();
      check("stall_vld",  32'(out_vld),  1);
      check("stall_data", 32'(out_data), 32'h0BAD);
      fx_read(DEV, 8'h02, "ovf_lo_set", 8'h04);
      fx_read(DEV, 8'h03, "ovf_hi",     8'h00);
      check("stall_data_held", 32'(out_data), 32'h0BAD);
      out_rdy = 1'b1;
      wait_drain();
      fx_write(8'h02, 8'h04);
      fx_read(DEV, 8'h02, "ovf_lo_cleared", 8'h00);

      phase = "frame";
      do_reset();
      out_rdy = 1'b0;
      expect_out(16'h2222, 4'd2, 1'b0);
      pulse_one(2, 16'h2222);
      tick();
      fx_write(8'h00, 8'h05);
      fx_write(8'h04, 8'h01);
      expect_out(16'hA000, 4'd0, 1'b1);
      expect_out(16'hD222, 4'd2, 1'b0);
      pulse_one(0, 16'hA000);
      pulse_one(0, 16'hB000);
      pulse_one(2, 16'hD222);
      out_rdy = 1'b1;
      wait_drain();
      expect_out(16'hC000, 4'd0, 1'b1);
      pulse_one(0, 16'hC000);
      wait_drain();
      fx_read(DEV, 8'h05, "fcnt_lo", 8'h01);
      fx_read(DEV, 8'h06, "fcnt_hi", 8'h00);
      fx_read(DEV, 8'h02, "ovf_lo",  8'h01);
      fx_read(DEV, 8'h04, "ctrl",    8'h01);

      phase = "same_cycle_reload";
      do_reset();
      expect_out(16'h1111, 4'd1, 1'b0);
      expect_out(16'h2222, 4'd1, 1'b0);
      pulse_one(1, 16'h1111);
      pulse_one(1, 16'h2222);
      wait_drain();
      fx_read(DEV, 8'h02, "ovf_lo", 8'h00);

      phase = "round_robin";
      do_reset();
      ch_data[0*DW +: DW] = 16'h00A0;
      ch_data[3*DW +: DW] = 16'h00B3;
      for (int i = 0; i < 7; i++) begin
         if (i % 2 == 0) expect_out(16'h00A0, 4'd0, 1'b0);
         else            expect_out(16'h00B3, 4'd3, 1'b0);
      end
      ch_vld = 8'h09;
      repeat (6) tick();
      ch_vld = '0;
      wait_drain();

      phase = "flush";
      do_reset();
      out_rdy = 1'b0;
      expect_out(16'h0101, 4'd1, 1'b0);
      pulse_one(1, 16'h0101);
      pulse_one(4, 16'h0404);
      fx_write(8'h04, 8'h02);
      fx_read(DEV, 8'h04, "ctrl_flush_reads_0", 8'h00);
      out_rdy = 1'b1;
      wait_drain();

      phase = "mask_zero";
      do_reset();
      fx_write(8'h00, 8'h00);
      ch_vld = '1;
      tick();
      ch_vld = '0;
      repeat (4) tick();
      check("no_output", 32'(out_vld), 0);
      fx_read(DEV, 8'h05, "fcnt_lo", 8'h00);

      phase = "reset_midstream";
      do_reset();
      mon_off = 1'b1;
      ch_vld = '1;
      tick();
      ch_vld = '0;
      repeat (2) tick();
      check("streaming_before_rst", 32'(out_vld), 1);
      rst = 1'b1;
      tick();
      check("vld_after_rst", 32'(out_vld), 0);
      rst = 1'b0;
      exp_q.delete();
      mon_off = 1'b0;
      repeat (3) tick();
      check("pending_lost", 32'(out_vld), 0);
      fx_read(DEV, 8'h00, "en_lo_restored", 8'hFF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
